// File: rtl/lap_store_if.sv
// Display-side bus of the lap-time buffer: live digits and controls in, display digits and status out.
interface lap_store_if #(
   parameter int IDXW = 3
);
   logic            lap_n;
   logic            clear;
   logic            recall;
   logic [IDXW-1:0] sel;
   logic [3:0]      du;
   logic [3:0]      dd;
   logic [3:0]      su;
   logic [3:0]      sd;
   logic [3:0]      out_du;
   logic [3:0]      out_dd;
   logic [3:0]      out_su;
   logic [3:0]      out_sd;
   logic [IDXW:0]   count;
   logic            full;
   logic            ovf;

   // Driver side: the counter, key and switches.
   modport master (
      output lap_n, clear, recall, sel, du, dd, su, sd,
      input  out_du, out_dd, out_su, out_sd, count, full, ovf
   );

   // Buffer side.
   modport slave (
      input  lap_n, clear, recall, sel, du, dd, su, sd,
      output out_du, out_dd, out_su, out_sd, count, full, ovf
   );
endinterface

// File: rtl/lap_store.sv
// Lap-time buffer: debounces the lap key, captures the running time into a
// DEPTH-entry buffer and shows either the live time or a recalled lap.
module lap_store #(
   parameter int DEPTH     = 8,
   parameter int IDXW      = 3,
   parameter int DEB_TICKS = 2
) (
   input logic        clock,
   input logic        reset,
   lap_store_if.slave bus
);

   localparam logic [IDXW:0] DEPTH_C   = (IDXW + 1)'(DEPTH);
   localparam logic [3:0]    DEB_LAST  = 4'(DEB_TICKS - 1);
   localparam logic [15:0]   BLANK     = 16'hFFFF;

   logic             sync1;
   logic             sync2;
   logic             deb_pressed;
   logic [3:0]       deb_cnt;
   logic             lap_evt;
   logic [IDXW:0]    count_q;
   logic             ovf_q;
   logic             full_w;
   logic             do_write;
   logic [15:0]      live_word;
   logic [15:0]      rec_q;
   logic [15:0]      out_word;
   logic [15:0]      mem [DEPTH];

   assign full_w    = (count_q == DEPTH_C);
   assign live_word = {bus.sd, bus.su, bus.dd, bus.du};
   // The write pointer always equals the number of stored laps, so count
   // doubles as the pointer; it cannot wrap because writes stop at full.
   assign do_write  = lap_evt && !bus.recall && !bus.clear && !full_w;

   // Two-flop synchronizer for the asynchronous key; idles at released (1).
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= bus.lap_n;
         sync2 <= sync1;
      end
   end

   // Debouncer: accept a new key level after DEB_TICKS consecutive differing
   // samples; pulse lap_evt only when the accepted level becomes pressed.
   always_ff @(posedge clock) begin
      if (!reset) begin
         deb_pressed <= 1'b0;
         deb_cnt     <= '0;
         lap_evt     <= 1'b0;
      end else begin
         lap_evt <= 1'b0;
         if (!sync2 == deb_pressed) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_pressed <= !sync2;
            deb_cnt     <= '0;
            lap_evt     <= !sync2;
         end else begin
            deb_cnt <= deb_cnt + 4'd1;
         end
      end
   end

   // Lap count and sticky overflow; clear takes priority over a press.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (bus.clear) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (lap_evt && !bus.recall) begin
         if (full_w) begin
            ovf_q <= 1'b1;
         end else begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   // Lap storage, written at the slot given by the current count.
   always_ff @(posedge clock) begin
      // NOTE: the lap memory has no reset; stale entries are hidden because only indices below count are shown.
      if (do_write) begin
         mem[count_q[IDXW-1:0]] <= live_word;
      end
   end

   // Recall register: selected lap if it exists, otherwise blank digits.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rec_q <= BLANK;
      end else if ({1'b0, bus.sel} < count_q) begin
         rec_q <= mem[bus.sel];
      end else begin
         rec_q <= BLANK;
      end
   end

   // Display mux: live digits pass straight through, recall uses the register.
   always_comb begin
      // NOTE: combinational outputs get a default first so no path can infer a latch.
      out_word = live_word;
      if (bus.recall) begin
         out_word = rec_q;
      end
   end

   assign {bus.out_sd, bus.out_su, bus.out_dd, bus.out_du} = out_word;
   assign bus.count = count_q;
   assign bus.full  = full_w;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_lap_store.sv
// Self-checking bench for lap_store: directed scenarios plus randomized key,
// mode and digit traffic, all compared against a lap-list reference model.
module tb_lap_store;

   localparam int DEPTH     = 8;
   localparam int IDXW      = 3;
   localparam int DEB_TICKS = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;

   lap_store_if #(.IDXW(IDXW)) bus ();

   lap_store #(
      .DEPTH    (DEPTH),
      .IDXW     (IDXW),
      .DEB_TICKS(DEB_TICKS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int passed = 0;

   // Reference model: a list of stored laps, the key level history and the
   // digits the recall register should hold.
   logic [15:0] m_mem [DEPTH];
   int          m_count;
   bit          m_ovf;
   logic [15:0] m_rec;
   bit          m_deb;      // 1 = key accepted as pressed
   bit          m_evt;      // press accepted at the last edge
   bit          hist[$];    // lap_n level sampled at each edge

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_edge();
      int  n;
      bit  flip;
      hist.push_back(bus.lap_n);
      if (hist.size() > 40) void'(hist.pop_front());
      if (!reset) begin
         m_count = 0;
         m_ovf   = 1'b0;
         m_rec   = 16'hFFFF;
         m_deb   = 1'b0;
         m_evt   = 1'b0;
         hist.delete();
         hist.push_back(1'b1);
         hist.push_back(1'b1);
         return;
      end
      m_rec = (int'(bus.sel) < m_count) ? m_mem[bus.sel] : 16'hFFFF;
      if (bus.clear) begin
         m_count = 0;
         m_ovf   = 1'b0;
      end else if (m_evt && !bus.recall) begin
         if (m_count < DEPTH) begin
            m_mem[m_count] = {bus.sd, bus.su, bus.dd, bus.du};
            m_count++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      // The key level seen by the debouncer lags lap_n by two edges; a new
      // level is accepted once DEB_TICKS seen samples all oppose the current one.
      n     = hist.size();
      flip  = 1'b0;
      m_evt = 1'b0;
      if (n >= 2 + DEB_TICKS) begin
         flip = 1'b1;
         for (int i = 0; i < DEB_TICKS; i++)
            if (hist[n-3-i] != m_deb) flip = 1'b0;
      end
      if (flip) begin
         m_deb = !m_deb;
         m_evt = m_deb;
      end
   endtask

   task automatic compare(input string tag);
      logic [15:0] exp_out;
      exp_out = bus.recall ? m_rec : {bus.sd, bus.su, bus.dd, bus.du};
      check({tag, ":count"}, 32'(bus.count), 32'(m_count));
      check({tag, ":full"},  32'(bus.full),  32'(m_count == DEPTH));
      check({tag, ":ovf"},   32'(bus.ovf),   32'(m_ovf));
      check({tag, ":out"},   {16'h0, bus.out_sd, bus.out_su, bus.out_dd, bus.out_du}, 32'(exp_out));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clock);
      #1;
      compare(tag);
   endtask

   task automatic set_live(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      bus.sd = a;
      bus.su = b;
      bus.dd = c;
      bus.du = d;
   endtask

   task automatic rand_live();
      set_live(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
   endtask

   // Clean press: hold the key down, then release long enough to settle.
   task automatic press(input string tag, input int hold);
      bus.lap_n = 1'b0;
      repeat (hold) tick(tag);
      bus.lap_n = 1'b1;
      repeat (5) tick(tag);
   endtask

   initial begin
      int run_left;
      bus.lap_n  = 1'b1;
      bus.clear  = 1'b0;
      bus.recall = 1'b0;
      bus.sel    = '0;
      set_live(4'd0, 4'd0, 4'd0, 4'd0);

      // Reset state
      reset = 1'b0;
      repeat (3) tick("reset");
      bus.recall = 1'b1;
      #1 compare("reset_blank");
      check("reset_out_blank", {16'h0, bus.out_sd, bus.out_su, bus.out_dd, bus.out_du}, 32'hFFFF);
      bus.recall = 1'b0;
      reset = 1'b1;
      repeat (3) tick("idle");

      // Single-cycle bounces must not register
      for (int i = 0; i < 4; i++) begin
         bus.lap_n = (i % 2 == 1);
         tick("bounce");
      end
      bus.lap_n = 1'b1;
      repeat (5) tick("bounce");
      check("bounce_count", 32'(bus.count), 32'd0);

      // Two captures, then recall them
      set_live(4'd1, 4'd2, 4'd3, 4'd4);
      press("press1", 4);
      check("press1_count", 32'(bus.count), 32'd1);
      set_live(4'd5, 4'd6, 4'd7, 4'd8);
      press("press2", 4);
      bus.recall = 1'b1;
      bus.sel    = 3'd1;
      tick("recall1");
      check("recall_sel1", {16'h0, bus.out_sd, bus.out_su, bus.out_dd, bus.out_du}, 32'h5678);
      bus.sel = 3'd2;
      tick("recall2");
      check("recall_sel2_blank", {16'h0, bus.out_sd, bus.out_su, bus.out_dd, bus.out_du}, 32'hFFFF);

      // Press in recall mode is discarded
      press("recall_press", 4);
      check("recall_press_count", 32'(bus.count), 32'd2);
      bus.recall = 1'b0;

      // Live digits pass through with zero latency
      for (int i = 0; i < 4; i++) begin
         rand_live();
         #1 compare("live");
      end

      // Fill to full and overflow
      for (int i = 0; i < 7; i++) begin
         rand_live();
         press("fill", 4);
      end
      check("fill_count", 32'(bus.count), 32'd8);
      check("fill_full", 32'(bus.full), 32'd1);
      check("fill_ovf", 32'(bus.ovf), 32'd1);
      bus.recall = 1'b1;
      for (int s = 0; s < DEPTH; s++) begin
         bus.sel = 3'(s);
         repeat (2) tick("sweep");
      end

      // Clear coinciding with the press event: clear wins
      bus.recall = 1'b0;
      rand_live();
      bus.lap_n = 1'b0;
      repeat (4) tick("clr_evt");
      bus.clear = 1'b1;
      bus.lap_n = 1'b1;
      tick("clr_evt");
      bus.clear = 1'b0;
      check("clr_evt_count", 32'(bus.count), 32'd0);
      check("clr_evt_ovf", 32'(bus.ovf), 32'd0);
      repeat (4) tick("clr_evt");
      set_live(4'd9, 4'd0, 4'd4, 4'd2);
      press("after_clear", 4);
      bus.recall = 1'b1;
      bus.sel    = 3'd0;
      repeat (2) tick("after_clear");
      check("after_clear_idx0", {16'h0, bus.out_sd, bus.out_su, bus.out_dd, bus.out_du}, 32'h9042);

      // Reset with five laps stored
      bus.recall = 1'b0;
      bus.clear  = 1'b1;
      tick("pre5");
      bus.clear  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_live();
         press("five", 4);
      end
      check("five_count", 32'(bus.count), 32'd5);
      bus.recall = 1'b1;
      reset = 1'b0;
      tick("reset5");
      reset = 1'b1;
      check("reset5_count", 32'(bus.count), 32'd0);
      check("reset5_out", {16'h0, bus.out_sd, bus.out_su, bus.out_dd, bus.out_du}, 32'hFFFF);
      repeat (3) tick("reset5");

      // Randomized traffic
      run_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (run_left == 0) begin
            bus.lap_n = 1'($urandom_range(0, 1));
            run_left  = $urandom_range(1, 6);
         end
         run_left--;
         if ($urandom_range(0, 7) == 0)  rand_live();
         if ($urandom_range(0, 23) == 0) bus.recall = !bus.recall;
         if ($urandom_range(0, 5) == 0)  bus.sel = 3'($urandom_range(0, DEPTH - 1));
         bus.clear = ($urandom_range(0, 79) == 0);
         reset     = ($urandom_range(0, 299) != 0);
         tick("rand");
      end
      reset = 1'b1;
      bus.clear = 1'b0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
